// File: rtl/grf_read_scoreboard.sv
// rtl/grf_read_scoreboard.sv - GRF read-side hazard scoreboard (option macro: GRF_SB_WB_BYPASS_EN)
module grf_read_scoreboard #(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 2,
  parameter int STALL_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [4:0]         iss_rs,
  input  logic [4:0]         iss_rt,
  input  logic               iss_use_rs,
  input  logic               iss_use_rt,
  input  logic               iss_wr_en,
  input  logic [4:0]         iss_waddr,
  input  logic               wb_en,
  input  logic [4:0]         wb_addr,
  input  logic               flush,
  input  logic               drain_req,
  output logic               drain_done,
  output logic [31:0]        busy_vec,
  output logic               err_uflow,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pend [32];
  logic [31:0]      wr_hit, wb_hit, busy_eff, inc, dec;
  logic             accept, hz, full, wb_slot, uflow_ev, all_empty;

  // Per-register decode of issue/write-back targets and effective busy view
  always_comb begin
    busy_vec = '0;
    wr_hit   = '0;
    wb_hit   = '0;
    busy_eff = '0;
    for (int r = 1; r < 32; r++) begin
      busy_vec[r] = (pend[r] != '0);
      wr_hit[r]   = iss_wr_en && (iss_waddr == 5'(r));
      wb_hit[r]   = wb_en && (wb_addr == 5'(r));
`ifdef GRF_SB_WB_BYPASS_EN
      // the last outstanding write commits now and the GRF forwards it
      busy_eff[r] = busy_vec[r] && !(wb_hit[r] && (pend[r] == CNT_W'(1)));
`else
      busy_eff[r] = busy_vec[r];
`endif
    end
  end

  // Hazard detection, issue handshake and counter update enables
  always_comb begin
`ifdef GRF_SB_WB_BYPASS_EN
    wb_slot = wb_en && (wb_addr == iss_waddr);
`else
    wb_slot = 1'b0;
`endif
    full      = (pend[iss_waddr] == CNT_W'(MAX_PEND)) && !wb_slot;
    hz        = (iss_use_rs && (iss_rs != 5'd0) && busy_eff[iss_rs]) ||
                (iss_use_rt && (iss_rt != 5'd0) && busy_eff[iss_rt]) ||
                (iss_wr_en && (iss_waddr != 5'd0) && full);
    iss_ready = (state_q == ST_RUN) && !flush && !hz;
    accept    = iss_valid && iss_ready;
    inc       = wr_hit & {32{accept}};
    dec       = wb_hit & busy_vec;
    uflow_ev  = wb_en && (wb_addr != 5'd0) && (pend[wb_addr] == '0) && !flush;
    all_empty = (busy_vec == '0);
  end

  // Pending-write counters; a simultaneous issue and write-back cancel out
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int r = 0; r < 32; r++) pend[r] <= '0;
    end else begin
      pend[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        if (inc[r] && !dec[r])      pend[r] <= pend[r] + 1'b1;
        else if (dec[r] && !inc[r]) pend[r] <= pend[r] - 1'b1;
      end
    end
  end

  // Sticky underflow flag and saturating stall statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      err_uflow <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (uflow_ev) err_uflow <= 1'b1;
      if (iss_valid && !iss_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Drain FSM next state; completion pulse while draining with nothing outstanding
  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    case (state_q)
      ST_RUN:   if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: if (all_empty) begin
        drain_done = !reset;
        state_d    = ST_RUN;
      end
      default:  state_d = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_grf_read_scoreboard.sv
// tb/tb_grf_read_scoreboard.sv - directed table-driven bench for grf_read_scoreboard
module tb_grf_read_scoreboard;

`ifdef GRF_SB_WB_BYPASS_EN
  localparam int BP = 1;
`else
  localparam int BP = 0;
`endif
  localparam int NB = 1 - BP;

  logic        clk = 1'b0;
  logic        reset, iss_valid, iss_ready, iss_use_rs, iss_use_rt, iss_wr_en;
  logic [4:0]  iss_rs, iss_rt, iss_waddr, wb_addr;
  logic        wb_en, flush, drain_req, drain_done, err_uflow;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  grf_read_scoreboard #(.MAX_PEND(3), .CNT_W(2), .STALL_W(16)) dut (
    .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt),
    .iss_wr_en(iss_wr_en), .iss_waddr(iss_waddr), .wb_en(wb_en), .wb_addr(wb_addr),
    .flush(flush), .drain_req(drain_req), .drain_done(drain_done), .busy_vec(busy_vec),
    .err_uflow(err_uflow), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       ut;
    logic       we;
    logic [4:0] wa;
    logic       wb;
    logic [4:0] wba;
    logic       fl;
    logic       exp_rdy;
    logic [31:0] exp_busy;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_use_rs = 0; iss_use_rt = 0;
    iss_wr_en = 0; iss_waddr = 0; wb_en = 0; wb_addr = 0; flush = 0; drain_req = 0;
  endtask

  task automatic issue_wr(input logic [4:0] a);
    idle();
    iss_valid = 1; iss_wr_en = 1; iss_waddr = a;
    #1;
    chk("issue_wr_ready", 32'(iss_ready), 32'd1);
    tick();
  endtask

  task automatic wb_only(input logic [4:0] a);
    idle();
    wb_en = 1; wb_addr = a;
    tick();
  endtask

  initial begin
    //          v  rs  rt  ur ut we wa  wb wba fl rdy busy
    tbl[0]  = '{1, 0,  0,  0, 0, 1, 5,  0, 0,  0, 1, 32'h0000_0020};
    tbl[1]  = '{0, 0,  0,  0, 0, 0, 0,  1, 5,  0, 1, 32'h0000_0000};
    tbl[2]  = '{1, 5,  0,  1, 0, 0, 0,  0, 0,  0, 1, 32'h0000_0000};
    tbl[3]  = '{1, 0,  0,  1, 0, 1, 10, 0, 0,  0, 1, 32'h0000_0400};
    tbl[4]  = '{1, 0,  10, 0, 1, 1, 11, 0, 0,  0, 0, 32'h0000_0400};
    tbl[5]  = '{1, 0,  10, 0, 0, 1, 11, 0, 0,  0, 1, 32'h0000_0C00};
    tbl[6]  = '{1, 0,  0,  0, 0, 1, 10, 0, 0,  0, 1, 32'h0000_0C00};
    tbl[7]  = '{0, 0,  0,  0, 0, 0, 0,  1, 10, 0, 1, 32'h0000_0C00};
    tbl[8]  = '{1, 0,  0,  0, 0, 1, 10, 1, 10, 0, 1, 32'h0000_0C00};
    tbl[9]  = '{0, 0,  0,  0, 0, 0, 0,  1, 10, 0, 1, 32'h0000_0800};
    tbl[10] = '{0, 0,  0,  0, 0, 0, 0,  1, 11, 0, 1, 32'h0000_0000};
    tbl[11] = '{1, 0,  0,  0, 0, 1, 12, 0, 0,  1, 0, 32'h0000_0000};

    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_err", 32'(err_uflow), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_done", 32'(drain_done), 32'd0);
    chk("rst_ready", 32'(iss_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      iss_valid = tbl[i].v;  iss_rs = tbl[i].rs;  iss_rt = tbl[i].rt;
      iss_use_rs = tbl[i].ur; iss_use_rt = tbl[i].ut; iss_wr_en = tbl[i].we;
      iss_waddr = tbl[i].wa;  wb_en = tbl[i].wb;  wb_addr = tbl[i].wba; flush = tbl[i].fl;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(iss_ready), 32'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d_busy", i), busy_vec, tbl[i].exp_busy);
    end
    idle();
    chk("tbl_err", 32'(err_uflow), 32'd0);
    chk("tbl_stall", 32'(stall_cnt), 32'd2);

    // read of a register whose only write commits in the same cycle
    issue_wr(5'd8);
    idle();
    iss_valid = 1; iss_use_rs = 1; iss_rs = 8; wb_en = 1; wb_addr = 8;
    #1;
    chk("byp_ready", 32'(iss_ready), 32'(BP));
    tick();
    wb_en = 0; wb_addr = 0;
    #1;
    chk("byp_ready_next", 32'(iss_ready), 32'd1);
    tick();
    idle();
    chk("byp_stall", 32'(stall_cnt), 32'(2 + NB));
    chk("byp_busy", busy_vec, 32'h0);

    // write-after-write depth limit on $31 and $0 immunity
    issue_wr(5'd31); issue_wr(5'd31); issue_wr(5'd31);
    idle();
    iss_valid = 1; iss_wr_en = 1; iss_waddr = 31;
    #1;
    chk("max_pend_ready", 32'(iss_ready), 32'd0);
    tick();
    idle();
    iss_valid = 1; iss_use_rs = 1; iss_use_rt = 1; iss_wr_en = 1;
    #1;
    chk("zero_ready", 32'(iss_ready), 32'd1);
    tick();
    idle();
    chk("zero_busy", busy_vec, 32'h8000_0000);
    chk("max_stall", 32'(stall_cnt), 32'(3 + NB));
    wb_only(31); wb_only(31); wb_only(31);
    idle();
    chk("max_clear", busy_vec, 32'h0);

    // underflow detection and stickiness
    wb_only(0);
    chk("uflow_zero_reg", 32'(err_uflow), 32'd0);
    wb_only(9);
    chk("uflow_set", 32'(err_uflow), 32'd1);
    issue_wr(5'd9);
    wb_only(9);
    idle();
    chk("uflow_sticky", 32'(err_uflow), 32'd1);
    chk("uflow_busy", busy_vec, 32'h0);

    // drain with outstanding writes
    issue_wr(5'd3); issue_wr(5'd3); issue_wr(5'd4);
    idle();
    drain_req = 1;
    #1;
    chk("drain_req_ready", 32'(iss_ready), 32'd1);
    tick();
    idle();
    iss_valid = 1; iss_wr_en = 1; iss_waddr = 7;
    #1;
    chk("drain_ready", 32'(iss_ready), 32'd0);
    chk("drain_done_early", 32'(drain_done), 32'd0);
    tick();
    wb_only(3); wb_only(3);
    idle();
    wb_en = 1; wb_addr = 4;
    #1;
    chk("drain_done_pend", 32'(drain_done), 32'd0);
    tick();
    idle();
    #1;
    chk("drain_done_pulse", 32'(drain_done), 32'd1);
    chk("drain_pulse_ready", 32'(iss_ready), 32'd0);
    tick();
    chk("drain_done_after", 32'(drain_done), 32'd0);
    chk("drain_run_ready", 32'(iss_ready), 32'd1);
    chk("drain_stall", 32'(stall_cnt), 32'(4 + NB));

    // flush in the middle of a drain
    issue_wr(5'd3);
    idle();
    drain_req = 1;
    tick();
    idle();
    flush = 1;
    #1;
    chk("flush_drain_now", 32'(drain_done), 32'd0);
    tick();
    idle();
    #1;
    chk("flush_drain_pulse", 32'(drain_done), 32'd1);
    tick();
    chk("flush_drain_after", 32'(drain_done), 32'd0);

    // drain requested while already empty
    drain_req = 1;
    #1;
    chk("empty_drain_req", 32'(drain_done), 32'd0);
    tick();
    idle();
    #1;
    chk("empty_drain_pulse", 32'(drain_done), 32'd1);
    tick();
    chk("empty_drain_after", 32'(drain_done), 32'd0);
    chk("empty_drain_ready", 32'(iss_ready), 32'd1);

    // reset while draining
    issue_wr(5'd3);
    idle();
    drain_req = 1;
    tick();
    idle();
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rst_drain_ready", 32'(iss_ready), 32'd1);
    chk("rst_drain_busy", busy_vec, 32'h0);
    chk("rst_drain_err", 32'(err_uflow), 32'd0);
    chk("rst_drain_stall", 32'(stall_cnt), 32'd0);
    tick();
    chk("rst_drain_nopulse", 32'(drain_done), 32'd0);

    // stall counter saturation
    issue_wr(5'd20);
    idle();
    iss_valid = 1; iss_use_rs = 1; iss_rs = 20;
    #1;
    chk("sat_ready", 32'(iss_ready), 32'd0);
    repeat (65536 + 5) tick();
    chk("sat_stall", 32'(stall_cnt), 32'h0000_FFFF);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
